pixel_streamer: RTL and testbench
=================================

PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of each pixel.
REQ-002 SHALL have parameter IMG_WIDTH, default 32, pixels per row.
REQ-003 SHALL have parameter IMG_HEIGHT, default 32, rows per frame.
REQ-004 SHALL have parameter LINE_GAP, default 0, idle cycles inserted after every row except the last.
REQ-005 SHALL have derived parameter ADDR_W = clog2(IMG_WIDTH*IMG_HEIGHT), the frame memory address width.
REQ-006 SHALL use one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-007 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have port wr_en  input  1  frame memory write strobe.
REQ-009 SHALL have port wr_addr  input  ADDR_W  raster address, row*IMG_WIDTH+col.
REQ-010 SHALL have port wr_data  input  DATA_WIDTH  pixel to store.
REQ-011 SHALL have port start  input  1  request to stream one frame.
REQ-012 SHALL have port hold  input  1  backpressure, suppresses pixel emission.
REQ-013 SHALL have port pixel_out  output  DATA_WIDTH  registered pixel data.
REQ-014 SHALL have port pixel_valid  output  1  pixel_out valid this cycle.
REQ-015 SHALL have port frame_start  output  1  one-cycle pulse preceding the first pixel.
REQ-016 SHALL have port busy  output  1  high from start acceptance until frame_done.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel.

Function
REQ-018 SHALL hold an internal IMG_WIDTH*IMG_HEIGHT x DATA_WIDTH frame memory, written at a clock edge when wr_en=1, busy=0 and wr_addr < IMG_WIDTH*IMG_HEIGHT; otherwise the write is dropped.
REQ-019 SHALL implement FSM states IDLE, START, STREAM, GAP, DONE.
REQ-020 SHALL transition IDLE->START on an edge with start=1; start SHALL be ignored in all other states.
REQ-021 SHALL, in START (one cycle), drive frame_start=1, pixel_valid=0, busy=1; the read address and the col/row counters SHALL be reset to 0; next state STREAM.
REQ-022 SHALL, on each STREAM cycle with hold=0, drive pixel_out<=mem[addr] and pixel_valid<=1 at the next edge, then advance addr and col.
REQ-023 SHALL, on a STREAM cycle with hold=1, drive pixel_valid<=0, hold pixel_out, and leave addr/col unchanged.
REQ-024 SHALL emit pixels in raster order, exactly IMG_WIDTH*IMG_HEIGHT valid cycles per frame, with no duplicates or skips.
REQ-025 SHALL enter GAP after a row's last pixel is issued when LINE_GAP>0 and the row is not the last; GAP SHALL last exactly LINE_GAP cycles with pixel_valid=0, independent of hold, then return to STREAM.
REQ-026 SHALL go directly to the next row in STREAM when LINE_GAP=0.
REQ-027 SHALL enter DONE after the last pixel is issued; in DONE (one cycle) it SHALL drive frame_done=1 and busy=0 at the following edge, then return to IDLE.
REQ-028 SHALL make write data from an edge where start is accepted together with wr_en visible in the stream (the write lands before the first read).
REQ-029 SHALL have all outputs registered; pixel_valid SHALL be 0 whenever frame_start or frame_done is 1.
REQ-030 SHALL accept a new start in IDLE on the cycle immediately after frame_done.

Reset
REQ-031 SHALL, on rst=1 at any time including mid-frame, immediately force state IDLE, clear the counters and address, and set pixel_out=0, pixel_valid=0, frame_start=0, busy=0, frame_done=0.
REQ-032 SHALL leave frame memory contents unchanged on reset.
REQ-033 SHALL not pulse frame_done for a frame aborted by reset.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3, DATA_WIDTH=16)
REQ-034 SHALL cover: load mem[i]=i+0x100, LINE_GAP=0, start pulse at cycle 0 -> frame_start=1 at cycle 1; pixel_valid=1 at cycles 2..13 with 0x100..0x10B; frame_done=1 at cycle 14; busy=1 at cycles 1..13.
REQ-035 SHALL cover: LINE_GAP=2 -> valid bursts of 4 pixels separated by exactly 2 invalid cycles, 12 pixels total, frame_done 1 cycle after pixel 0x10B.
REQ-036 SHALL cover: hold=1 for 3 cycles after pixel 0x102 -> 3 invalid cycles, then 0x103 follows with no loss or duplicate; frame_done is delayed by 3 cycles.
REQ-037 SHALL cover: wr_en with wr_addr=5, data 0xBEEF while busy -> the write is ignored and the next frame still outputs 0x105 at position 5.
REQ-038 SHALL cover: rst=1 after pixel 0x106 -> all outputs 0 immediately, no frame_done; a following start streams the full frame from 0x100.
REQ-039 SHALL cover: start asserted during STREAM -> ignored, with exactly 12 pixels and one frame_done.

Source files
------------

// File: rtl/pixel_streamer.sv
// Frame-buffered pixel streamer: a host fills an internal frame memory, then
// each start request replays the frame in raster order with optional line gaps.
module pixel_streamer #(
  parameter int  DATA_WIDTH = 16,
  parameter int  IMG_WIDTH  = 32,
  parameter int  IMG_HEIGHT = 32,
  parameter int  LINE_GAP   = 0,
  localparam int NPIX       = IMG_WIDTH * IMG_HEIGHT,
  localparam int ADDR_W     = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_valid,
  output logic                  frame_start,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int GAP_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

  typedef enum logic [2:0] {IDLE, START, STREAM, GAP, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [NPIX];
  logic [ADDR_W-1:0]     addr;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  last_col;
  logic                  last_row;
  logic                  wr_ok;

  assign last_col = (col == COL_W'(IMG_WIDTH - 1));
  assign last_row = (row == ROW_W'(IMG_HEIGHT - 1));
  assign wr_ok    = wr_en && !busy && (32'(wr_addr) < NPIX);

  // Frame memory survives reset; host writes are locked out while a frame streams.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // START and STREAM both issue a pixel on their edge, so the first pixel
  // appears the cycle right after frame_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      col         <= '0;
      row         <= '0;
      gap_cnt     <= '0;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      pixel_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= START;
            frame_start <= 1'b1;
            busy        <= 1'b1;
            addr        <= '0;
            col         <= '0;
            row         <= '0;
          end
        end
        START, STREAM: begin
          if (hold) begin
            state <= STREAM;
          end else begin
            pixel_out   <= mem[addr];
            pixel_valid <= 1'b1;
            addr        <= addr + 1'b1;
            if (last_col) begin
              col <= '0;
              row <= row + 1'b1;
              if (last_row) begin
                state <= DONE;
              end else if (LINE_GAP > 0) begin
                state   <= GAP;
                gap_cnt <= '0;
              end else begin
                state <= STREAM;
              end
            end else begin
              col   <= col + 1'b1;
              state <= STREAM;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(LINE_GAP - 1)) state <= STREAM;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_streamer.sv
// Bench for pixel_streamer: two instances (LINE_GAP 0 and 2) share stimulus;
// expected pixels, pulse times and busy windows come from an issue-time model.
module tb_pixel_streamer;
  localparam int DW   = 16;
  localparam int IW   = 4;
  localparam int IH   = 3;
  localparam int NPIX = IW * IH;
  localparam int AW   = 4;
  localparam int MAXO = 128;

  typedef struct packed {
    logic [DW-1:0] px;
    int            at;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [DW-1:0] po0, po1;
  logic          pv0, pv1, fs0, fs1, bz0, bz1, fd0, fd1;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  exp_t          pq [2][$];
  int            fsq [2][$];
  int            fdq [2][$];
  int            blo [2];
  int            bhi [2];
  int            done_off [2];
  logic [DW-1:0] last_po [2];
  logic [DW-1:0] mm [2][NPIX];

  bit            hold_pat [MAXO];
  bit            st_pat [MAXO];
  bit            we_pat [MAXO];
  int            wa_pat [MAXO];
  logic [DW-1:0] wd_pat [MAXO];

  pixel_streamer #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .LINE_GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .hold(hold), .pixel_out(po0), .pixel_valid(pv0),
    .frame_start(fs0), .busy(bz0), .frame_done(fd0)
  );

  pixel_streamer #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .LINE_GAP(2)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .hold(hold), .pixel_out(po1), .pixel_valid(pv1),
    .frame_start(fs1), .busy(bz1), .frame_done(fd1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d: got %0h, required %0h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic flag(input string nm, input int d, input int val);
    n_cmp++;
    n_fail++;
    $display("FAIL %s dut%0d cyc=%0d: got %0h, required none", nm, d, cyc, val);
  endtask

  task automatic mon(input int d, input logic pv, input logic [DW-1:0] po,
                     input logic fs, input logic fd, input logic bz);
    exp_t e;
    chk("busy", d, 64'(bz), 64'(cyc >= blo[d] && cyc <= bhi[d]));
    if (fs || fd) chk("valid_excl", d, 64'(pv), 64'(0));
    while (pq[d].size() > 0 && pq[d][0].at < cyc) begin
      e = pq[d].pop_front();
      flag("pixel_missing", d, int'(e.px));
    end
    while (fsq[d].size() > 0 && fsq[d][0] < cyc) flag("frame_start_missing", d, fsq[d].pop_front());
    while (fdq[d].size() > 0 && fdq[d][0] < cyc) flag("frame_done_missing", d, fdq[d].pop_front());
    if (pv) begin
      if (pq[d].size() == 0) flag("pixel_unexpected", d, int'(po));
      else begin
        e = pq[d].pop_front();
        chk("pixel_data", d, 64'(po), 64'(e.px));
        chk("pixel_cyc", d, 64'(cyc), 64'(e.at));
      end
      last_po[d] = po;
    end else begin
      chk("po_hold", d, 64'(po), 64'(last_po[d]));
    end
    if (fs) begin
      if (fsq[d].size() == 0) flag("frame_start_unexpected", d, cyc);
      else chk("frame_start_cyc", d, 64'(cyc), 64'(fsq[d].pop_front()));
    end
    if (fd) begin
      if (fdq[d].size() == 0) flag("frame_done_unexpected", d, cyc);
      else chk("frame_done_cyc", d, 64'(cyc), 64'(fdq[d].pop_front()));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, pv0, po0, fs0, fd0, bz0);
      mon(1, pv1, po1, fs1, fd1, bz1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input int a, input logic [DW-1:0] v);
    if (a < NPIX) begin
      mm[0][a] = v;
      mm[1][a] = v;
    end
  endtask

  task automatic clear_pats();
    for (int o = 0; o < MAXO; o++) begin
      hold_pat[o] = 1'b0;
      st_pat[o]   = 1'b0;
      we_pat[o]   = 1'b0;
      wa_pat[o]   = 0;
      wd_pat[o]   = '0;
    end
  endtask

  // Pixel k is issued at the first edge, no earlier than one after the previous
  // issue (plus the line gap on a new row), at which hold is low.
  task automatic plan_frame(input int s);
    int g, e, prev;
    for (int d = 0; d < 2; d++) begin
      g = (d == 0) ? 0 : 2;
      prev = 0;
      for (int k = 0; k < NPIX; k++) begin
        e = (k == 0) ? 1 : prev + 1 + (((k % IW) == 0) ? g : 0);
        while (e < MAXO - 1 && hold_pat[e]) e++;
        pq[d].push_back(exp_t'{px: mm[d][k], at: s + e + 1});
        prev = e;
      end
      fsq[d].push_back(s + 1);
      fdq[d].push_back(s + prev + 2);
      blo[d] = s + 1;
      bhi[d] = s + prev + 1;
      done_off[d] = prev + 2;
    end
  endtask

  task automatic do_abort();
    rst = 1'b1;
    start = 1'b0;
    hold = 1'b0;
    wr_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      pq[d].delete();
      fsq[d].delete();
      fdq[d].delete();
      blo[d] = 0;
      bhi[d] = -1;
      last_po[d] = '0;
    end
    #1;
    chk("abort_pixel_out", 0, 64'(po0), 64'(0));
    chk("abort_pixel_valid", 0, 64'(pv0), 64'(0));
    chk("abort_busy", 0, 64'(bz0), 64'(0));
    chk("abort_pixel_out", 1, 64'(po1), 64'(0));
    chk("abort_pixel_valid", 1, 64'(pv1), 64'(0));
    chk("abort_busy", 1, 64'(bz1), 64'(0));
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_frame(input int abort_off, input bit rnd);
    int s;
    s = cyc;
    if (we_pat[0]) model_write(wa_pat[0], wd_pat[0]);
    plan_frame(s);
    if (rnd) begin
      for (int o = 1; o < done_off[0]; o++) begin
        st_pat[o] = ($urandom % 6) == 0;
        we_pat[o] = ($urandom % 4) == 0;
        wa_pat[o] = int'($urandom_range(15, 0));
        wd_pat[o] = 16'($urandom);
      end
    end
    for (int o = 0; o < done_off[1]; o++) begin
      if (o == abort_off) begin
        do_abort();
        return;
      end
      start   = (o == 0) || st_pat[o];
      hold    = hold_pat[o];
      wr_en   = we_pat[o];
      wr_addr = AW'(wa_pat[o]);
      wr_data = wd_pat[o];
      tick();
    end
    start = 1'b0;
    hold  = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n, input bit rnd);
    int a;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        a = int'($urandom_range(15, 0));
        wr_en = ($urandom % 2) == 1;
        wr_addr = AW'(a);
        wr_data = 16'($urandom);
        if (wr_en) model_write(a, wr_data);
      end
      tick();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached after %0d comparisons", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      blo[d] = 0;
      bhi[d] = -1;
      last_po[d] = '0;
      for (int k = 0; k < NPIX; k++) mm[d][k] = '0;
    end
    #1 rst = 1'b1;
    #1;
    chk("reset_pixel_out", 0, 64'(po0), 64'(0));
    chk("reset_pixel_valid", 0, 64'(pv0), 64'(0));
    chk("reset_frame_start", 0, 64'(fs0), 64'(0));
    chk("reset_busy", 0, 64'(bz0), 64'(0));
    chk("reset_frame_done", 0, 64'(fd0), 64'(0));
    chk("reset_pixel_out", 1, 64'(po1), 64'(0));
    chk("reset_pixel_valid", 1, 64'(pv1), 64'(0));
    chk("reset_frame_start", 1, 64'(fs1), 64'(0));
    chk("reset_busy", 1, 64'(bz1), 64'(0));
    chk("reset_frame_done", 1, 64'(fd1), 64'(0));
    mon_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Load the ramp, plus one out-of-range write that must be dropped.
    for (int i = 0; i < NPIX; i++) begin
      wr_en = 1'b1;
      wr_addr = AW'(i);
      wr_data = 16'(16'h100 + i);
      model_write(i, wr_data);
      tick();
    end
    wr_addr = AW'(13);
    wr_data = 16'hDEAD;
    model_write(13, wr_data);
    tick();
    wr_en = 1'b0;
    idle(2, 1'b0);

    // Plain frame, no backpressure.
    clear_pats();
    run_frame(-1, 1'b0);
    idle(1, 1'b0);

    // Three held cycles after 0x102, a busy-time write, and a stray start.
    clear_pats();
    hold_pat[4] = 1'b1;
    hold_pat[5] = 1'b1;
    hold_pat[6] = 1'b1;
    we_pat[3] = 1'b1;
    wa_pat[3] = 5;
    wd_pat[3] = 16'hBEEF;
    st_pat[7] = 1'b1;
    st_pat[9] = 1'b1;
    run_frame(-1, 1'b0);

    // Back-to-back start on the frame_done cycle; 0x105 must still be there.
    clear_pats();
    run_frame(-1, 1'b0);
    idle(2, 1'b0);

    // Reset mid-frame once 0x106 has been shown, then a clean full frame.
    clear_pats();
    run_frame(11, 1'b0);
    idle(2, 1'b0);
    clear_pats();
    run_frame(-1, 1'b0);

    // Randomised frames: backpressure, start+write on the same edge, stray traffic.
    for (int f = 0; f < 10; f++) begin
      idle(int'($urandom_range(3, 0)), 1'b1);
      clear_pats();
      for (int o = 1; o < 40; o++) hold_pat[o] = ($urandom % 4) == 0;
      we_pat[0] = ($urandom % 2) == 1;
      wa_pat[0] = int'($urandom_range(15, 0));
      wd_pat[0] = 16'($urandom);
      run_frame(-1, 1'b1);
    end

    idle(4, 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk("pending_pixels", d, 64'(pq[d].size()), 64'(0));
      chk("pending_frame_done", d, 64'(fdq[d].size()), 64'(0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
